// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and limits for the serial sum deserializer
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - bit position counter: load-to-1, increment, terminal at WIDTH-1
module bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     load,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     terminal
);

    localparam int CW = $clog2(WIDTH);

    assign terminal = (count == CW'(WIDTH - 1));

    // Saturates at the terminal value so the count can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (inc && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_sum_deserializer.sv
// rtl/serial_sum_deserializer.sv - collects LSB-first sum bits into a word plus carry
module serial_sum_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             start,
    input  logic             s_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] word_out,
    output logic             carry_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] full_word;
    logic [CW-1:0]    count;
    logic             terminal;
    logic             take_first, take_next, complete;
    logic             set_ferr, set_ovr;

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (complete),
        .load     (take_first),
        .inc      (take_next),
        .count    (count),
        .terminal (terminal)
    );

    // Shift register with the incoming bit merged at the current position.
    always_comb begin
        full_word        = shreg;
        full_word[count] = s_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        take_first = 1'b0;
        take_next  = 1'b0;
        complete   = 1'b0;
        set_ferr   = 1'b0;
        set_ovr    = 1'b0;
        case (state)
            IDLE: begin
                if (bit_valid && start) begin
                    take_first = 1'b1;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (start) begin
                        set_ferr   = 1'b1;
                        take_first = 1'b1;
                    end else if (terminal) begin
                        complete  = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        take_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Handshake cycle may also carry bit 0 of the next word.
                if (word_ready) begin
                    if (bit_valid && start) begin
                        take_first = 1'b1;
                        state_nxt  = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (bit_valid) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            word_out  <= '0;
            carry_out <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (take_first) begin
                shreg <= {{(WIDTH-1){1'b0}}, s_in};
            end else if (take_next) begin
                shreg <= full_word;
            end
            if (complete) begin
                word_out  <= full_word;
                carry_out <= cout_in;
            end
            // A same-cycle setting event takes priority over the clear.
            if (set_ferr) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy       = (state == SHIFT);
    assign word_valid = (state == HOLD);

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// tb/tb_serial_sum_deserializer.sv - self-checking bench for serial_sum_deserializer
module tb_serial_sum_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         bit_valid = 1'b0;
    logic         start = 1'b0;
    logic         s_in = 1'b0;
    logic         cout_in = 1'b0;
    logic         word_ready = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] word_out;
    logic         carry_out;
    logic         word_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t1;

    serial_sum_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .start      (start),
        .s_in       (s_in),
        .cout_in    (cout_in),
        .word_out   (word_out),
        .carry_out  (carry_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: bit list per word, a holding slot and two sticky flags.
    bit          m_coll, m_hold, m_ferr, m_ovr, m_carry;
    int          m_idx;
    logic [W-1:0] m_bits, m_word;

    always @(posedge clk or negedge reset) begin : model
        bit sf, so;
        if (!reset) begin
            m_coll = 0; m_hold = 0; m_ferr = 0; m_ovr = 0; m_carry = 0;
            m_idx = 0; m_bits = '0; m_word = '0;
        end else begin
            sf = 0;
            so = 0;
            if (m_hold) begin
                if (word_ready) begin
                    m_hold = 0;
                    if (bit_valid && start) begin
                        m_coll = 1; m_bits = '0; m_bits[0] = s_in; m_idx = 1;
                    end
                end else if (bit_valid) begin
                    so = 1;
                end
            end else if (m_coll) begin
                if (bit_valid) begin
                    if (start) begin
                        sf = 1; m_bits = '0; m_bits[0] = s_in; m_idx = 1;
                    end else begin
                        m_bits[m_idx] = s_in;
                        m_idx++;
                        if (m_idx == W) begin
                            m_coll = 0; m_hold = 1; m_word = m_bits; m_carry = cout_in;
                        end
                    end
                end
            end else if (bit_valid && start) begin
                m_coll = 1; m_bits = '0; m_bits[0] = s_in; m_idx = 1;
            end
            m_ferr = sf ? 1'b1 : (err_clr ? 1'b0 : m_ferr);
            m_ovr  = so ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy", 32'(busy), 32'(m_coll));
        chk("cmp_valid", 32'(word_valid), 32'(m_hold));
        chk("cmp_word", 32'(word_out), 32'(m_word));
        chk("cmp_carry", 32'(carry_out), 32'(m_carry));
        chk("cmp_ferr", 32'(frame_err), 32'(m_ferr));
        chk("cmp_ovr", 32'(overrun), 32'(m_ovr));
    end

    function automatic logic [W:0] mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic s, input logic st, input logic co);
        bit_valid = 1'b1; start = st; s_in = s; cout_in = co;
        tick();
        bit_valid = 1'b0; start = 1'b0; s_in = 1'b0; cout_in = 1'b0;
    endtask

    task automatic send_word(input logic [W:0] sum, input int gap);
        for (int i = 0; i < W; i++) begin
            send_bit(sum[i], i == 0, (i == W-1) ? sum[W] : 1'b0);
            if (i < W-1) repeat (gap) tick();
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_word", 32'(word_out), 32'd0);
        reset = 1'b1;
        tick();

        // 1: reset mid-word, then a clean word
        word_ready = 1'b1;
        send_bit(1, 1, 0);
        send_bit(0, 0, 0);
        send_bit(1, 0, 0);
        chk("t1_busy_mid", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t1_async_busy", 32'(busy), 32'd0);
        chk("t1_async_valid", 32'(word_valid), 32'd0);
        chk("t1_async_word", 32'(word_out), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        send_word(mk(8'h2D, 8'h2D, 1'b0), 0);
        chk("t1_word", 32'(word_out), 32'h5A);
        chk("t1_valid", 32'(word_valid), 32'd1);
        tick();

        // 2: 0xA5 with carry, one-cycle valid
        send_word(mk(8'hF0, 8'hB4, 1'b1), 0);
        chk("t2_valid", 32'(word_valid), 32'd1);
        chk("t2_word", 32'(word_out), 32'hA5);
        chk("t2_carry", 32'(carry_out), 32'd1);
        tick();
        chk("t2_valid_drop", 32'(word_valid), 32'd0);

        // 3: gapped bits, held word, overrun
        word_ready = 1'b0;
        send_word(mk(8'h1E, 8'h1E, 1'b0), 2);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(word_valid), 32'd1);
            chk("t3_hold_word", 32'(word_out), 32'h3C);
            tick();
        end
        send_bit(1, 0, 1);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_word_kept", 32'(word_out), 32'h3C);
        chk("t3_carry", 32'(carry_out), 32'd0);
        word_ready = 1'b1;
        tick();
        chk("t3_released", 32'(word_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_ovr_clr", 32'(overrun), 32'd0);

        // 4: early start aborts a word
        send_bit(1, 1, 0);
        send_bit(1, 0, 0);
        send_bit(1, 0, 0);
        send_bit(1, 0, 0);
        send_word(mk(8'h80, 8'h80, 1'b1), 0);
        chk("t4_ferr", 32'(frame_err), 32'd1);
        chk("t4_word", 32'(word_out), 32'h01);
        chk("t4_carry", 32'(carry_out), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_ferr_clr", 32'(frame_err), 32'd0);

        // 5: back-to-back words
        send_word(mk(8'h21, 8'h21, 1'b0), 0);
        chk("t5_first", 32'(word_out), 32'h42);
        t1 = cyc;
        send_word(mk(8'hC0, 8'hC0, 1'b1), 0);
        chk("t5_second_valid", 32'(word_valid), 32'd1);
        chk("t5_second_word", 32'(word_out), 32'h81);
        chk("t5_second_carry", 32'(carry_out), 32'd1);
        chk("t5_latency", 32'(cyc - t1), 32'd8);
        tick();

        // 6: stray bits in IDLE
        for (int i = 0; i < 3; i++) send_bit(1, 0, 1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_valid", 32'(word_valid), 32'd0);
        chk("t6_ferr", 32'(frame_err), 32'd0);
        chk("t6_ovr", 32'(overrun), 32'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
